// File: rtl/uart_rx_if.sv
// uart_rx_if: byte-side and line-side signals of the UART receiver.
// The master side drives the serial line and the read strobe. The slave side
// is the receiver, which returns the buffered byte and its status flags.
interface uart_rx_if;
    logic       rx;
    logic       read_en;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_error;
    logic       overrun;

    modport master (
        output rx,
        output read_en,
        input  data,
        input  data_valid,
        input  frame_error,
        input  overrun
    );

    modport slave (
        input  rx,
        input  read_en,
        output data,
        output data_valid,
        output frame_error,
        output overrun
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a one-entry byte buffer.
// The line is synchronised, and the start bit is confirmed at its centre.
// Each following bit is then sampled one bit period after the previous one.
// Completed bytes are held until the CPU reads them. A low stop bit is
// reported as a sticky framing error, and a byte that lands on an unread
// byte is reported as a sticky overrun.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.slave  bus
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT / 2) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Synchroniser flops (idle level is 1)
    logic             sync_meta_r;
    logic             rx_s;

    // Frame FSM and datapath
    state_t           state_r;
    state_t           state_nxt;
    logic [CNT_W-1:0] clk_cnt_r;
    logic [CNT_W-1:0] clk_cnt_nxt;
    logic [2:0]       bit_idx_r;
    logic [2:0]       bit_idx_nxt;
    logic [7:0]       shift_r;
    logic [7:0]       shift_nxt;

    // One-cycle frame outcome strobes from the FSM
    logic             complete_s;
    logic             stop_bad_s;

    // Registered outputs
    logic [7:0]       data_r;
    logic             data_valid_r;
    logic             frame_error_r;
    logic             overrun_r;

    // Two-flop synchroniser bringing the asynchronous pin into the clk domain
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta_r <= 1'b1;
            rx_s        <= 1'b1;
        end else begin
            sync_meta_r <= bus.rx;
            rx_s        <= sync_meta_r;
        end
    end

    // FSM state, bit-period counter, bit index and shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            clk_cnt_r <= {CNT_W{1'b0}};
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
        end else begin
            state_r   <= state_nxt;
            clk_cnt_r <= clk_cnt_nxt;
            bit_idx_r <= bit_idx_nxt;
            shift_r   <= shift_nxt;
        end
    end

    // Next-state logic: centre-of-bit sampling and frame outcome strobes
    always_comb begin
        state_nxt   = state_r;
        clk_cnt_nxt = clk_cnt_r;
        bit_idx_nxt = bit_idx_r;
        shift_nxt   = shift_r;
        complete_s  = 1'b0;
        stop_bad_s  = 1'b0;

        case (state_r)
            IDLE: begin
                if (rx_s == 1'b0) begin
                    clk_cnt_nxt = {CNT_W{1'b0}};
                    state_nxt   = START;
                end else begin
                    state_nxt   = IDLE;
                end
            end

            START: begin
                if (clk_cnt_r == CNT_HALF) begin
                    // Still low at mid-bit is a real start bit. Otherwise it was a glitch.
                    if (rx_s == 1'b0) begin
                        clk_cnt_nxt = {CNT_W{1'b0}};
                        bit_idx_nxt = 3'd0;
                        state_nxt   = DATA;
                    end else begin
                        state_nxt   = IDLE;
                    end
                end else begin
                    clk_cnt_nxt = clk_cnt_r + CNT_W'(1);
                end
            end

            DATA: begin
                if (clk_cnt_r == CNT_LAST) begin
                    shift_nxt   = {rx_s, shift_r[7:1]};
                    clk_cnt_nxt = {CNT_W{1'b0}};
                    if (bit_idx_r == 3'd7) begin
                        state_nxt   = STOP;
                    end else begin
                        bit_idx_nxt = bit_idx_r + 3'd1;
                    end
                end else begin
                    clk_cnt_nxt = clk_cnt_r + CNT_W'(1);
                end
            end

            STOP: begin
                if (clk_cnt_r == CNT_LAST) begin
                    // Leaving at stop-bit centre lets an immediate next start bit be seen
                    clk_cnt_nxt = {CNT_W{1'b0}};
                    state_nxt   = IDLE;
                    if (rx_s == 1'b1) begin
                        complete_s = 1'b1;
                    end else begin
                        stop_bad_s = 1'b1;
                    end
                end else begin
                    clk_cnt_nxt = clk_cnt_r + CNT_W'(1);
                end
            end

            default: begin
                state_nxt   = IDLE;
                clk_cnt_nxt = {CNT_W{1'b0}};
                bit_idx_nxt = 3'd0;
            end
        endcase
    end

    // Byte buffer and sticky status flags, including the completion/read interplay
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r        <= 8'h00;
            data_valid_r  <= 1'b0;
            frame_error_r <= 1'b0;
            overrun_r     <= 1'b0;
        end else if (complete_s) begin
            data_r       <= shift_r;
            data_valid_r <= 1'b1;
            if (bus.read_en) begin
                // The read consumes the old byte. The new byte takes its place, so nothing is lost.
                frame_error_r <= 1'b0;
                overrun_r     <= 1'b0;
            end else if (data_valid_r) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= overrun_r;
            end
        end else if (stop_bad_s) begin
            // A fresh framing error is kept even when a read lands in the same cycle
            frame_error_r <= 1'b1;
            if (bus.read_en) begin
                data_valid_r <= 1'b0;
                overrun_r    <= 1'b0;
            end else begin
                data_valid_r <= data_valid_r;
            end
        end else if (bus.read_en) begin
            data_valid_r  <= 1'b0;
            frame_error_r <= 1'b0;
            overrun_r     <= 1'b0;
        end else begin
            data_valid_r  <= data_valid_r;
        end
    end

    assign bus.data        = data_r;
    assign bus.data_valid  = data_valid_r;
    assign bus.frame_error = frame_error_r;
    assign bus.overrun     = overrun_r;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomised, self-checking bench for uart_rx.
// Serial frames are driven onto rx, and the receiver's outputs are compared
// against a byte-level model of the buffer and its flags.
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int LAT = 9 * CPB + CPB / 2 + 3;   // pin falling edge to data_valid

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_rx_if bus ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running core clock
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Byte-level reference state
    logic [7:0] exp_data  = 8'h00;
    logic       exp_valid = 1'b0;
    logic       exp_fe    = 1'b0;
    logic       exp_ov    = 1'b0;

    // Observations recorded by send_frame
    int         rise_at;
    logic [7:0] rise_data;
    bit         last_was_valid;

    function automatic void model_reset();
        exp_data  = 8'h00;
        exp_valid = 1'b0;
        exp_fe    = 1'b0;
        exp_ov    = 1'b0;
    endfunction

    function automatic void model_read();
        exp_valid = 1'b0;
        exp_fe    = 1'b0;
        exp_ov    = 1'b0;
    endfunction

    // read_mode: 0 = no read, 1 = read coincides with completion, 2 = read shortly after
    function automatic void model_frame(input logic [7:0] b, input logic stop_ok, input int read_mode);
        if (stop_ok) begin
            if (read_mode == 1) begin
                exp_fe = 1'b0;
                exp_ov = 1'b0;
            end else if (exp_valid) begin
                exp_ov = 1'b1;
            end
            exp_data  = b;
            exp_valid = 1'b1;
        end else begin
            if (read_mode == 1) model_read();
            exp_fe = 1'b1;
        end
        if (read_mode == 2) model_read();
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.rx      = 1'b1;
            bus.read_en = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic pulse_read();
        @(posedge clk); #1;
        bus.read_en = 1'b1;
        @(posedge clk); #1;
        bus.read_en = 1'b0;
        @(negedge clk);
        model_read();
    endtask

    // Drive one 8N1 frame, optionally with a read or a 1-cycle reset at chosen points
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int read_mode, input int rst_at);
        logic [9:0] sh;
        bit aborted;
        sh = {stop_bit, b, 1'b0};
        aborted = 1'b0;
        rise_at = -1;
        rise_data = 8'h00;
        last_was_valid = exp_valid;
        for (int k = 0; k < 10 * CPB; k++) begin
            @(posedge clk); #1;
            if (k > 0 && (k % CPB) == 0) sh = sh >> 1;
            if (k == rst_at) aborted = 1'b1;
            bus.rx      = aborted ? 1'b1 : sh[0];
            bus.read_en = (read_mode == 1 && k == LAT - 1) || (read_mode == 2 && k == LAT + 2);
            rst         = (k == rst_at);
            @(negedge clk);
            if (!last_was_valid && rise_at < 0 && bus.data_valid === 1'b1) begin
                rise_at   = k;
                rise_data = bus.data;
            end
        end
        if (aborted) model_reset();
        else model_frame(b, stop_bit, read_mode);
    endtask

    task automatic test_reset();
        vectors++; if (bus.data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h exp 00", bus.data); end
        vectors++; if (bus.data_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b exp 0", bus.data_valid); end
        vectors++; if (bus.frame_error !== 1'b0) begin miscompares++; $display("FAIL reset_fe: got %b exp 0", bus.frame_error); end
        vectors++; if (bus.overrun !== 1'b0) begin miscompares++; $display("FAIL reset_ov: got %b exp 0", bus.overrun); end
    endtask

    task automatic test_single_byte();
        send_frame(8'hA5, 1'b1, 0, -1);
        vectors++; if (rise_at < LAT - 1 || rise_at > LAT + 1) begin miscompares++; $display("FAIL single_latency: got %0d exp %0d+-1", rise_at, LAT); end
        vectors++; if (rise_data !== 8'hA5) begin miscompares++; $display("FAIL single_data: got %h exp a5", rise_data); end
        vectors++; if (bus.data_valid !== exp_valid) begin miscompares++; $display("FAIL single_valid: got %b exp %b", bus.data_valid, exp_valid); end
        pulse_read();
        vectors++; if (bus.data_valid !== 1'b0) begin miscompares++; $display("FAIL single_read_valid: got %b exp 0", bus.data_valid); end
        vectors++; if (bus.data !== 8'hA5) begin miscompares++; $display("FAIL single_read_data: got %h exp a5", bus.data); end
    endtask

    task automatic test_back_to_back();
        send_frame(8'h00, 1'b1, 2, -1);
        vectors++; if (rise_at < 0 || rise_data !== 8'h00) begin miscompares++; $display("FAIL b2b_first: got %h at %0d exp 00", rise_data, rise_at); end
        send_frame(8'hFF, 1'b1, 2, -1);
        vectors++; if (rise_at < 0 || rise_data !== 8'hFF) begin miscompares++; $display("FAIL b2b_second: got %h at %0d exp ff", rise_data, rise_at); end
        vectors++; if (bus.frame_error !== 1'b0 || bus.overrun !== 1'b0) begin miscompares++; $display("FAIL b2b_flags: got fe=%b ov=%b exp 0 0", bus.frame_error, bus.overrun); end
        vectors++; if (bus.data !== 8'hFF) begin miscompares++; $display("FAIL b2b_data: got %h exp ff", bus.data); end
    endtask

    task automatic test_glitch();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 4 * CPB; i++) begin
            @(posedge clk); #1;
            bus.rx = (i < 4) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (bus.data_valid !== 1'b0 || bus.frame_error !== 1'b0 || bus.overrun !== 1'b0) seen = 1'b1;
        end
        vectors++; if (seen) begin miscompares++; $display("FAIL glitch_flags: got a flag raised exp none"); end
        send_frame(8'h6B, 1'b1, 0, -1);
        vectors++; if (bus.data !== 8'h6B || bus.data_valid !== 1'b1) begin miscompares++; $display("FAIL glitch_after: got %h/%b exp 6b/1", bus.data, bus.data_valid); end
        pulse_read();
    endtask

    task automatic test_frame_error();
        logic [7:0] prev;
        prev = exp_data;
        send_frame(8'h3C, 1'b0, 0, -1);
        idle(2 * CPB);
        vectors++; if (bus.frame_error !== 1'b1) begin miscompares++; $display("FAIL fe_set: got %b exp 1", bus.frame_error); end
        vectors++; if (bus.data_valid !== 1'b0) begin miscompares++; $display("FAIL fe_valid: got %b exp 0", bus.data_valid); end
        vectors++; if (bus.data !== prev) begin miscompares++; $display("FAIL fe_data: got %h exp %h", bus.data, prev); end
        pulse_read();
        vectors++; if (bus.frame_error !== 1'b0) begin miscompares++; $display("FAIL fe_clear: got %b exp 0", bus.frame_error); end
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b1, 0, -1);
        send_frame(8'h22, 1'b1, 0, -1);
        vectors++; if (bus.data !== 8'h22 || bus.data_valid !== 1'b1) begin miscompares++; $display("FAIL ov_data: got %h/%b exp 22/1", bus.data, bus.data_valid); end
        vectors++; if (bus.overrun !== 1'b1) begin miscompares++; $display("FAIL ov_set: got %b exp 1", bus.overrun); end
        pulse_read();
        send_frame(8'h11, 1'b1, 0, -1);
        send_frame(8'h22, 1'b1, 1, -1);
        vectors++; if (bus.overrun !== 1'b0) begin miscompares++; $display("FAIL ov_read_same: got %b exp 0", bus.overrun); end
        vectors++; if (bus.data !== 8'h22 || bus.data_valid !== 1'b1) begin miscompares++; $display("FAIL ov_read_data: got %h/%b exp 22/1", bus.data, bus.data_valid); end
        send_frame(8'h33, 1'b1, 0, -1);
        vectors++; if (bus.overrun !== exp_ov) begin miscompares++; $display("FAIL ov_again: got %b exp %b", bus.overrun, exp_ov); end
    endtask

    task automatic test_reset_mid_frame();
        send_frame(8'h5A, 1'b1, 0, 5 * CPB + CPB / 2);
        idle(2 * CPB);
        vectors++; if (bus.data !== 8'h00 || bus.data_valid !== 1'b0) begin miscompares++; $display("FAIL rmf_data: got %h/%b exp 00/0", bus.data, bus.data_valid); end
        vectors++; if (bus.frame_error !== 1'b0 || bus.overrun !== 1'b0) begin miscompares++; $display("FAIL rmf_flags: got fe=%b ov=%b exp 0 0", bus.frame_error, bus.overrun); end
        send_frame(8'hC3, 1'b1, 0, -1);
        vectors++; if (bus.data !== 8'hC3 || bus.data_valid !== 1'b1) begin miscompares++; $display("FAIL rmf_next: got %h/%b exp c3/1", bus.data, bus.data_valid); end
        pulse_read();
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic       stop_ok;
        int         mode;
        for (int n = 0; n < 14; n++) begin
            b       = 8'($urandom_range(0, 255));
            stop_ok = ($urandom_range(0, 5) != 0);
            mode    = $urandom_range(0, 2);
            send_frame(b, stop_ok, mode, -1);
            if (!stop_ok) idle(2 * CPB);
            else if ($urandom_range(0, 1) == 1) idle($urandom_range(1, CPB));
            if (stop_ok && !last_was_valid) begin
                vectors++; if (rise_at < LAT - 1 || rise_at > LAT + 1 || rise_data !== b) begin miscompares++; $display("FAIL rnd_rise[%0d]: got %h at %0d exp %h at %0d", n, rise_data, rise_at, b, LAT); end
            end
            vectors++; if (bus.data !== exp_data) begin miscompares++; $display("FAIL rnd_data[%0d]: got %h exp %h", n, bus.data, exp_data); end
            vectors++; if (bus.data_valid !== exp_valid) begin miscompares++; $display("FAIL rnd_valid[%0d]: got %b exp %b", n, bus.data_valid, exp_valid); end
            vectors++; if (bus.frame_error !== exp_fe) begin miscompares++; $display("FAIL rnd_fe[%0d]: got %b exp %b", n, bus.frame_error, exp_fe); end
            vectors++; if (bus.overrun !== exp_ov) begin miscompares++; $display("FAIL rnd_ov[%0d]: got %b exp %b", n, bus.overrun, exp_ov); end
        end
        pulse_read();
    endtask

    task automatic test_break();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 22 * CPB; i++) begin
            @(posedge clk); #1;
            bus.rx = 1'b0;
            @(negedge clk);
            if (bus.data_valid !== 1'b0) seen = 1'b1;
        end
        vectors++; if (seen) begin miscompares++; $display("FAIL break_valid: got data_valid=1 exp 0"); end
        vectors++; if (bus.frame_error !== 1'b1) begin miscompares++; $display("FAIL break_fe: got %b exp 1", bus.frame_error); end
        @(posedge clk); #1;
        bus.rx = 1'b1;
        rst    = 1'b1;
        @(posedge clk); #1;
        rst    = 1'b0;
        model_reset();
        idle(2 * CPB);
        vectors++; if (bus.frame_error !== 1'b0) begin miscompares++; $display("FAIL break_rst: got %b exp 0", bus.frame_error); end
    endtask

    // Scenario sequence
    initial begin
        bus.rx      = 1'b1;
        bus.read_en = 1'b0;
        rst         = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_reset_mid_frame();
        test_random();
        test_break();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
